// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - instruction-fetch sequencer between the PC and instruction memory
module fetch_controller #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] pc_in,
    output logic              pc_write,
    output logic [ADDR_W-1:0] next_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [DATA_W-1:0] if_instr,
    output logic [ADDR_W-1:0] if_pc,
    output logic              fetch_fault
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_RESP  = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [2:0] S_FAULT = 3'd5;

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  wait_q, wait_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] if_pc_q, if_pc_d;
    logic [DATA_W-1:0] instr_q, instr_d;

    logic              aligned;
    logic              accept;
    logic [CNT_W-1:0]  wait_inc;
    logic              wait_hit;

    assign aligned  = (pc_in[1:0] == 2'b00);
    assign accept   = (state_q == S_HOLD) && if_ready;
    assign wait_inc = wait_q + CNT_W'(1);
    assign wait_hit = (wait_inc == CNT_W'(TIMEOUT));

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        addr_d  = addr_q;
        instr_d = instr_q;
        if_pc_d = if_pc_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
                wait_d  = '0;
            end
            S_REQ: begin
                if (!aligned) begin
                    state_d = S_FAULT;
                end else if (imem_gnt) begin
                    state_d = S_RESP;
                    addr_d  = pc_in;
                    wait_d  = '0;
                end else if (wait_hit) begin
                    state_d = S_FAULT;
                end else begin
                    wait_d = wait_inc;
                end
            end
            S_RESP: begin
                if (imem_rvalid) begin
                    state_d = S_HOLD;
                    instr_d = imem_rdata;
                    if_pc_d = addr_q;
                end else if (wait_hit) begin
                    state_d = S_FAULT;
                end else begin
                    wait_d = wait_inc;
                end
            end
            S_HOLD: begin
                if (if_ready) begin
                    state_d = S_REQ;
                    wait_d  = '0;
                end
            end
            S_DRAIN: begin
                if (imem_rvalid) begin
                    state_d = S_IDLE;
                end else if (wait_hit) begin
                    state_d = S_FAULT;
                end else begin
                    wait_d = wait_inc;
                end
            end
            default: state_d = S_FAULT;
        endcase

        // A redirect overrides everything; a granted-but-unanswered read must be drained.
        if (redirect) begin
            instr_d = instr_q;
            if_pc_d = if_pc_q;
            wait_d  = '0;
            case (state_q)
                S_REQ:   state_d = (aligned && imem_gnt) ? S_DRAIN : S_IDLE;
                S_RESP:  state_d = imem_rvalid ? S_IDLE : S_DRAIN;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
            addr_q  <= '0;
            instr_q <= '0;
            if_pc_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
            if_pc_q <= if_pc_d;
        end
    end

    assign imem_req    = (state_q == S_REQ) && aligned;
    assign imem_addr   = imem_req ? pc_in : '0;
    assign if_valid    = (state_q == S_HOLD);
    assign if_instr    = instr_q;
    assign if_pc       = if_pc_q;
    assign fetch_fault = (state_q == S_FAULT);
    assign pc_write    = redirect || accept;
    assign next_pc     = redirect ? redirect_pc :
                         accept   ? if_pc_q + ADDR_W'(4) : '0;

endmodule

// File: tb/tb_fetch_controller.sv
// tb/tb_fetch_controller.sv - directed-vector bench for fetch_controller
module tb_fetch_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_in;
    logic        pc_write;
    logic [31:0] next_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        fetch_fault;

    int n_checks = 0;
    int n_errors = 0;

    bit          auto_gnt = 1'b1;
    bit          auto_rsp = 1'b1;
    bit          man_rv   = 1'b0;
    logic [31:0] man_data = '0;
    bit          pend     = 1'b0;
    logic [31:0] pend_addr = '0;

    always #5 clk = ~clk;

    fetch_controller #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc_in       (pc_in),
        .pc_write    (pc_write),
        .next_pc     (next_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_valid    (if_valid),
        .if_ready    (if_ready),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .fetch_fault (fetch_fault)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Live program counter
    always @(posedge clk) begin
        if (!rst_n) pc_in <= '0;
        else if (pc_write) pc_in <= next_pc;
    end

    // Memory: grant immediately, answer one cycle later with word = addr + 0x1000_0000
    initial begin
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (man_rv) begin
                imem_rvalid = 1'b1;
                imem_rdata  = man_data;
                pend        = 1'b0;
                man_rv      = 1'b0;
            end else if (pend && auto_rsp) begin
                imem_rvalid = 1'b1;
                imem_rdata  = pend_addr + 32'h1000_0000;
                pend        = 1'b0;
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = '0;
            end
            imem_gnt = auto_gnt && imem_req;
            if (imem_gnt) begin
                pend      = 1'b1;
                pend_addr = imem_addr;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #2;
            check_eq("req_and_valid_exclusive", imem_req & if_valid, 0);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_pc_write"}, pc_write, 0);
        check_eq({tag, "_next_pc"}, next_pc, 0);
        check_eq({tag, "_imem_req"}, imem_req, 0);
        check_eq({tag, "_imem_addr"}, imem_addr, 0);
        check_eq({tag, "_if_valid"}, if_valid, 0);
        check_eq({tag, "_if_instr"}, if_instr, 0);
        check_eq({tag, "_if_pc"}, if_pc, 0);
        check_eq({tag, "_fetch_fault"}, fetch_fault, 0);
    endtask

    initial begin
        rst_n       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        if_ready    = 1'b1;
        repeat (3) tick();
        check_all_zero("reset");
        rst_n = 1'b1;

        // Sequential fetch, zero-wait memory
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq("seq_req", imem_req, 1);
            check_eq("seq_addr", imem_addr, 32'(4 * k));
            tick();
            check_eq("seq_resp_no_req", imem_req, 0);
            tick();
            check_eq("seq_if_valid", if_valid, 1);
            check_eq("seq_if_instr", if_instr, 32'h1000_0000 + 32'(4 * k));
            check_eq("seq_pc_write", pc_write, 1);
            check_eq("seq_next_pc", next_pc, 32'(4 * k + 4));
        end
        tick();
        check_eq("seq_addr_c", imem_addr, 32'hC);

        // Decode stall
        if_ready = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("stall_if_valid", if_valid, 1);
            check_eq("stall_if_instr", if_instr, 32'h1000_000C);
            check_eq("stall_if_pc", if_pc, 32'hC);
            check_eq("stall_pc_write", pc_write, 0);
            check_eq("stall_imem_req", imem_req, 0);
        end
        if_ready = 1'b1;
        #1;
        check_eq("release_pc_write", pc_write, 1);
        check_eq("release_next_pc", next_pc, 32'h10);
        tick();
        check_eq("release_single_pulse", pc_write, 0);
        check_eq("release_addr", imem_addr, 32'h10);

        // Redirect while waiting for the response
        auto_rsp = 1'b0;
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h1000;
        #1;
        check_eq("resp_redir_pc_write", pc_write, 1);
        check_eq("resp_redir_next_pc", next_pc, 32'h1000);
        tick();
        redirect = 1'b0;
        man_data = 32'hDEAD;
        man_rv   = 1'b1;
        auto_rsp = 1'b1;
        check_eq("drain_if_valid", if_valid, 0);
        for (int i = 0; i < 2; i++) begin
            tick();
            check_eq("drain_if_valid", if_valid, 0);
        end
        tick();
        check_eq("redir_req", imem_req, 1);
        check_eq("redir_addr", imem_addr, 32'h1000);
        tick();
        tick();
        check_eq("redir_if_valid", if_valid, 1);
        check_eq("redir_if_instr", if_instr, 32'h1000_1000);
        check_eq("redir_if_pc", if_pc, 32'h1000);
        check_eq("redir_next_pc", next_pc, 32'h1004);

        // Grant timeout
        auto_gnt = 1'b0;
        repeat (16) tick();
        check_eq("to_req_still", imem_req, 1);
        check_eq("to_no_fault_yet", fetch_fault, 0);
        tick();
        check_eq("to_fault", fetch_fault, 1);
        check_eq("to_req_low", imem_req, 0);
        check_eq("to_if_valid", if_valid, 0);
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        auto_gnt    = 1'b1;
        #1;
        check_eq("to_redir_next_pc", next_pc, 32'h40);
        tick();
        redirect = 1'b0;
        check_eq("to_fault_cleared", fetch_fault, 0);
        tick();
        check_eq("to_req_40", imem_req, 1);
        check_eq("to_addr_40", imem_addr, 32'h40);

        // Redirect during accepted handshake, to a misaligned target
        tick();
        tick();
        check_eq("hs_if_valid", if_valid, 1);
        check_eq("hs_if_pc", if_pc, 32'h40);
        redirect    = 1'b1;
        redirect_pc = 32'h1002;
        #1;
        check_eq("hs_redir_pc_write", pc_write, 1);
        check_eq("hs_redir_next_pc", next_pc, 32'h1002);
        tick();
        redirect = 1'b0;
        check_eq("hs_if_valid_drop", if_valid, 0);
        tick();
        check_eq("mis_no_req", imem_req, 0);
        check_eq("mis_no_fault_yet", fetch_fault, 0);
        tick();
        check_eq("mis_fault", fetch_fault, 1);
        check_eq("mis_no_req2", imem_req, 0);

        // Address wrap
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        #1;
        check_eq("wrap_redir_next_pc", next_pc, 32'hFFFF_FFFC);
        tick();
        redirect = 1'b0;
        check_eq("wrap_fault_cleared", fetch_fault, 0);
        tick();
        check_eq("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        tick();
        tick();
        check_eq("wrap_if_pc", if_pc, 32'hFFFF_FFFC);
        check_eq("wrap_if_instr", if_instr, 32'h0FFF_FFFC);
        check_eq("wrap_pc_write", pc_write, 1);
        check_eq("wrap_next_pc", next_pc, 32'h0);
        tick();
        check_eq("wrap_req_0", imem_req, 1);
        check_eq("wrap_addr_0", imem_addr, 32'h0);

        // Reset in the middle of a response wait
        auto_rsp = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        check_all_zero("midreset");
        man_data = 32'hBAD;
        man_rv   = 1'b1;
        auto_rsp = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("post_reset_req", imem_req, 1);
        check_eq("post_reset_addr", imem_addr, 32'h0);
        check_eq("post_reset_if_valid", if_valid, 0);
        tick();
        tick();
        check_eq("post_reset_if_valid2", if_valid, 1);
        check_eq("post_reset_if_instr", if_instr, 32'h1000_0000);

        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
